// File: rtl/tree_level_loader_pkg.sv
// tree_pkg: shared key width, address-width helper and loader state encoding
package tree_pkg;
    localparam int KEY_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int addr_w(input int level);
        return (level > 0) ? level : 1;
    endfunction
endpackage

// File: rtl/tree_level_loader_if.sv
// tree_level_loader_if: configuration stream in, node-RAM write port out
interface tree_level_loader_if #(parameter int aw = 12);
    import tree_pkg::*;
    logic [KEY_W-1:0] cfg_data;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             wr_en;
    logic [aw-1:0]    wr_addr;
    logic [KEY_W-1:0] wr_data;
    modport master (output cfg_data, cfg_valid, input cfg_ready, wr_en, wr_addr, wr_data);
    modport slave  (input cfg_data, cfg_valid, output cfg_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/tree_level_loader.sv
// tree_level_loader: loads one tree level's threshold RAM from a ready/valid stream
module tree_level_loader
    import tree_pkg::*;
#(
    parameter int level       = 12,
    parameter int total_level = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    tree_level_loader_if.slave  bus,
    output logic                lookup_hold,
    output logic                done,
    output logic                aborted,
    output logic [KEY_W-1:0]    csum
);
    localparam int AW = addr_w(level);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << level) - 1);

    if (level < 0 || level > total_level) begin : g_range
        $error("tree_level_loader: level outside 0..total_level");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [KEY_W-1:0] xr;
    logic             acc;

    assign bus.cfg_ready = state == LOAD;
    assign acc = bus.cfg_valid && state == LOAD;

    // FSM plus write register, node counter and running checksum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            xr          <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            lookup_hold <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            csum        <= '0;
        end else begin
            bus.wr_en <= acc;
            done      <= 1'b0;
            aborted   <= 1'b0;
            if (acc) begin
                bus.wr_addr <= cnt[AW-1:0];
                bus.wr_data <= bus.cfg_data;
                xr          <= xr ^ bus.cfg_data;
                cnt         <= cnt + 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    state       <= LOAD;
                    cnt         <= '0;
                    xr          <= '0;
                    lookup_hold <= 1'b1;
                end
                LOAD: if (abort) begin
                    state       <= IDLE;
                    aborted     <= 1'b1;
                    lookup_hold <= 1'b0;
                end else if (acc && cnt == LAST) begin
                    state <= DRAIN;
                end
                DRAIN: if (abort) begin
                    state       <= IDLE;
                    aborted     <= 1'b1;
                    lookup_hold <= 1'b0;
                end else begin
                    state <= DONE;
                    done  <= 1'b1;
                    csum  <= xr;
                end
                default: begin
                    state       <= IDLE;
                    lookup_hold <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tree_level_loader.sv
// tb_tree_level_loader: scoreboard bench over three loaders (levels 2, 0, 3)
module tb_tree_level_loader;
    import tree_pkg::*;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    localparam logic [1:0] EV_W = 2'd0, EV_D = 2'd1, EV_A = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start [3];
    logic abort_r [3];
    logic cv [3];
    logic [15:0] cd [3];
    logic rdy [3], we [3], hold [3], dn [3], ab [3];
    logic [15:0] wa [3], wd [3], cs [3];
    ev_t q [3][$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tree_level_loader_if #(.aw(2)) b0 ();
    tree_level_loader_if #(.aw(1)) b1 ();
    tree_level_loader_if #(.aw(3)) b2 ();

    assign b0.cfg_data = cd[0];
    assign b0.cfg_valid = cv[0];
    assign b1.cfg_data = cd[1];
    assign b1.cfg_valid = cv[1];
    assign b2.cfg_data = cd[2];
    assign b2.cfg_valid = cv[2];
    assign rdy[0] = b0.cfg_ready;
    assign rdy[1] = b1.cfg_ready;
    assign rdy[2] = b2.cfg_ready;
    assign we[0] = b0.wr_en;
    assign we[1] = b1.wr_en;
    assign we[2] = b2.wr_en;
    assign wa[0] = 16'(b0.wr_addr);
    assign wa[1] = 16'(b1.wr_addr);
    assign wa[2] = 16'(b2.wr_addr);
    assign wd[0] = b0.wr_data;
    assign wd[1] = b1.wr_data;
    assign wd[2] = b2.wr_data;

    tree_level_loader #(.level(2), .total_level(12)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort_r[0]), .bus(b0),
        .lookup_hold(hold[0]), .done(dn[0]), .aborted(ab[0]), .csum(cs[0]));
    tree_level_loader #(.level(0), .total_level(12)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort_r[1]), .bus(b1),
        .lookup_hold(hold[1]), .done(dn[1]), .aborted(ab[1]), .csum(cs[1]));
    tree_level_loader #(.level(3), .total_level(12)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort_r[2]), .bus(b2),
        .lookup_hold(hold[2]), .done(dn[2]), .aborted(ab[2]), .csum(cs[2]));

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic push(int k, logic [1:0] kind, logic [15:0] a, logic [15:0] d);
        q[k].push_back('{kind, a, d});
    endtask

    task automatic mon(int k, logic [1:0] kind, logic [15:0] a, logic [15:0] d);
        ev_t e;
        if (q[k].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event dut%0d: got kind %0d addr %h data %h expected none", k, kind, a, d);
        end else begin
            e = q[k].pop_front();
            chk($sformatf("kind dut%0d", k), 32'(kind), 32'(e.kind));
            chk($sformatf("addr dut%0d", k), 32'(a), 32'(e.addr));
            chk($sformatf("data dut%0d", k), 32'(d), 32'(e.data));
        end
    endtask

    // monitor: every write, done and aborted pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (we[k]) mon(k, EV_W, wa[k], wd[k]);
                if (dn[k]) mon(k, EV_D, 16'h0, cs[k]);
                if (ab[k]) mon(k, EV_A, 16'h0, 16'h0);
            end
        end
    end

    task automatic pstart(int k);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic send(int k, logic [15:0] d);
        int n = 0;
        cd[k] = d;
        cv[k] = 1'b1;
        while (!rdy[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk($sformatf("ready_timeout dut%0d", k), 32'(rdy[k]), 32'd1);
        end else begin
            @(negedge clk);
        end
        cv[k] = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            abort_r[k] = 1'b0;
            cv[k] = 1'b0;
            cd[k] = 16'h0;
        end
        #1;
        chk("rst wr_en", 32'(we[0]), 32'd0);
        chk("rst wr_addr", 32'(wa[0]), 32'd0);
        chk("rst wr_data", 32'(wd[0]), 32'd0);
        chk("rst hold", 32'(hold[0]), 32'd0);
        chk("rst done", 32'(dn[0]), 32'd0);
        chk("rst aborted", 32'(ab[0]), 32'd0);
        chk("rst csum", 32'(cs[0]), 32'd0);
        chk("rst cfg_ready", 32'(rdy[0]), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 4; i++) push(0, EV_W, 16'(i), 16'(16 * (i + 1)));
        push(0, EV_D, 16'h0, 16'h0040);
        pstart(0);
        chk("t1 hold after start", 32'(hold[0]), 32'd1);
        send(0, 16'h0010);
        send(0, 16'h0020);
        send(0, 16'h0030);
        send(0, 16'h0040);
        chk("t1 hold drain", 32'(hold[0]), 32'd1);
        chk("t1 done early", 32'(dn[0]), 32'd0);
        idle(1);
        chk("t1 done pulse", 32'(dn[0]), 32'd1);
        chk("t1 hold in done", 32'(hold[0]), 32'd1);
        idle(1);
        chk("t1 hold released", 32'(hold[0]), 32'd0);
        chk("t1 cfg_ready idle", 32'(rdy[0]), 32'd0);

        for (int i = 0; i < 4; i++) push(0, EV_W, 16'(i), 16'(16 * (i + 1)));
        push(0, EV_D, 16'h0, 16'h0040);
        pstart(0);
        send(0, 16'h0010);
        send(0, 16'h0020);
        idle(3);
        send(0, 16'h0030);
        send(0, 16'h0040);
        idle(3);

        push(0, EV_W, 16'd0, 16'hAAAA);
        push(0, EV_W, 16'd1, 16'h5555);
        push(0, EV_A, 16'h0, 16'h0);
        pstart(0);
        send(0, 16'hAAAA);
        send(0, 16'h5555);
        abort_r[0] = 1'b1;
        idle(1);
        abort_r[0] = 1'b0;
        chk("t3 aborted pulse", 32'(ab[0]), 32'd1);
        chk("t3 cfg_ready", 32'(rdy[0]), 32'd0);
        chk("t3 hold", 32'(hold[0]), 32'd0);
        chk("t3 csum kept", 32'(cs[0]), 32'h0040);
        idle(3);
        chk("t3 cfg_ready later", 32'(rdy[0]), 32'd0);

        for (int i = 0; i < 4; i++) push(0, EV_W, 16'(i), 16'(1 << i));
        push(0, EV_D, 16'h0, 16'h000F);
        pstart(0);
        send(0, 16'h0001);
        start[0] = 1'b1;
        send(0, 16'h0002);
        send(0, 16'h0004);
        start[0] = 1'b0;
        send(0, 16'h0008);
        idle(4);
        chk("t6 csum", 32'(cs[0]), 32'h000F);

        push(1, EV_W, 16'd0, 16'hBEEF);
        push(1, EV_D, 16'h0, 16'hBEEF);
        pstart(1);
        send(1, 16'hBEEF);
        idle(3);
        chk("t4 csum", 32'(cs[1]), 32'hBEEF);
        chk("t4 hold", 32'(hold[1]), 32'd0);

        for (int i = 0; i < 5; i++) push(2, EV_W, 16'(i), 16'h0100 + 16'(i));
        pstart(2);
        for (int i = 0; i < 5; i++) send(2, 16'h0100 + 16'(i));
        #2 rst = 1'b1;
        #1;
        chk("t5 wr_en", 32'(we[2]), 32'd0);
        chk("t5 wr_addr", 32'(wa[2]), 32'd0);
        chk("t5 wr_data", 32'(wd[2]), 32'd0);
        chk("t5 hold", 32'(hold[2]), 32'd0);
        chk("t5 cfg_ready", 32'(rdy[2]), 32'd0);
        chk("t5 done", 32'(dn[2]), 32'd0);
        chk("t5 aborted", 32'(ab[2]), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        for (int i = 1; i <= 8; i++) push(2, EV_W, 16'(i - 1), 16'h0101 * 16'(i));
        push(2, EV_D, 16'h0, 16'h0808);
        pstart(2);
        for (int i = 1; i <= 8; i++) send(2, 16'h0101 * 16'(i));
        idle(4);
        chk("t5 csum", 32'(cs[2]), 32'h0808);

        for (int k = 0; k < 3; k++) chk($sformatf("pending dut%0d", k), 32'(q[k].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tree_level_loader.md
Name: tree_level_loader

Overview:
- Write-side companion to the per-level lookup stage. It programs one tree level's node-threshold RAM from a configuration stream.
- It accepts a ready/valid stream of 16-bit thresholds after a start command and emits sequential RAM write strobes (address 0 .. 2**level-1).
- It raises a hold flag so the lookup pipeline of that level is quiesced while the level is being loaded.
- One instance sits beside each tree level's node RAM, fed by the AFU's configuration path.

Parameters:
- level, 12, tree level served; node count NN = 2**level.
- total_level, 12, depth of the whole tree; informational only, used for the range assertion level <= total_level.

Ports:
- clk  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin loading the level.
- abort  input  1  cancels a load in progress.
- cfg_data  input  16  threshold word for the next node.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  loader accepts a beat this cycle.
- wr_en  output  1  node-RAM write strobe.
- wr_addr  output  AW  node-RAM write address; AW = (level>0) ? level : 1.
- wr_data  output  16  node-RAM write data.
- lookup_hold  output  1  lookup stage must drive valid_in low.
- done  output  1  one-cycle pulse when all NN words have been written.
- aborted  output  1  one-cycle pulse when a load was cancelled.
- csum  output  16  XOR of all words of the last completed load.

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE. Counter=0, running xor=0. All outputs = 0: cfg_ready, wr_en, wr_addr, wr_data, lookup_hold, done, aborted, csum.
- Decided: one clock; reset is asynchronous and active-high.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - cfg_ready=0, lookup_hold=0.
  - start=1 -> LOAD; counter cleared, xor cleared.
  - abort in IDLE is ignored.
- LOAD:
  - cfg_ready=1 combinationally from state; lookup_hold=1.
  - Beat accepted when cfg_valid && cfg_ready.
  - Next cycle after acceptance: wr_en=1, wr_addr=counter, wr_data=cfg_data. Registered; latency 1 cycle.
  - On acceptance, xor ^= cfg_data and counter increments.
  - Accepting the beat with counter==NN-1 -> DRAIN; cfg_ready falls the following cycle.
  - start while in LOAD is ignored; the load does not restart.
- DRAIN:
  - One cycle; the final wr_en is emitted; lookup_hold stays 1.
  - Then -> DONE.
- DONE:
  - One cycle; done=1; csum <= final xor; lookup_hold=1.
  - Then -> IDLE; lookup_hold falls the following cycle.
- Abort:
  - abort=1 in LOAD or DRAIN -> IDLE next cycle; aborted pulses 1 cycle.
  - A beat accepted in the same cycle as abort is still written; no further beats are accepted.
  - csum is unchanged and the RAM contents are partial.
  - abort has priority over the LOAD->DRAIN transition.
- wr_en is 0 in every cycle without an accepted beat in the previous cycle. Gaps in cfg_valid simply stall; there is no timeout.
- Counter width AW+1, so NN-1 is reached without wrap; the counter is never compared beyond NN-1.
- level=0 (NN=1): a single beat goes LOAD->DRAIN; wr_addr is always 0.
- Reset mid-load: immediate return to IDLE, outputs zeroed, no done or aborted pulse.

Decomposition:
- Shared package tree_pkg holds:
  - KEY_W=16
  - the function addr_w(level) returning max(level,1)
  - the state encoding constants: IDLE=2'd0, LOAD=2'd1, DRAIN=2'd2, DONE=2'd3
- No sub-module: FSM, counter and write register live in one module.
- The existing tree_bram gains a write port driven by wr_en/wr_addr/wr_data (separate change).

Test Plan:
1. level=2, rst released, start, 4 beats 0x0010, 0x0020, 0x0030, 0x0040 back-to-back -> wr_en on 4 consecutive cycles, addr 0..3, data as sent; done pulses 2 cycles after the last beat; csum=0x0040; lookup_hold high from the cycle after start until the cycle after done.
2. level=2, same data, cfg_valid low for 3 cycles between beats 2 and 3 -> identical writes, only delayed; no spurious wr_en.
3. level=2, abort after 2 beats (0xAAAA, 0x5555) -> 2 writes; aborted pulses; done never pulses; csum keeps its previous value; cfg_ready=0 afterwards.
4. level=0, start, one beat 0xBEEF -> single write, addr 0, data 0xBEEF; done; csum=0xBEEF.
5. rst asserted asynchronously mid-load at level=3 after 5 beats -> all outputs 0 immediately, no done pulse; a fresh start then loads 8 words correctly.
6. start pulsed repeatedly during LOAD at level=2 -> ignored; exactly 4 writes and one done pulse.
